// File: rtl/write_line_buffer.sv
// Single-entry store-merge buffer: collects CPU byte/word stores into one
// 128-bit line image and drains it to the lower level as a single burst.
module write_line_buffer (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_write,
  input  logic [15:0]  cpu_address,
  input  logic [15:0]  cpu_wdata,
  input  logic [1:0]   cpu_wmask,
  output logic         cpu_resp,
  input  logic         flush,
  output logic         empty,
  input  logic [15:0]  snoop_address,
  output logic         snoop_hit,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [127:0] mem_wdata,
  output logic [15:0]  mem_bytemask,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {StEmpty, StHold, StDrain} state_e;

  state_e       state_q, state_d;
  logic [11:0]  tag_q, tag_d;
  logic [127:0] line_q, line_d;
  logic [15:0]  mask_q, mask_d;

  logic       tag_match;
  logic       accept;
  logic [2:0] word;
  logic [6:0] lo_base, hi_base;
  logic [3:0] lo_bit, hi_bit;
  logic       unused_addr_bits;

  assign word      = cpu_address[3:1];
  assign lo_base   = {word, 4'b0000};
  assign hi_base   = {word, 4'b1000};
  assign lo_bit    = {word, 1'b0};
  assign hi_bit    = {word, 1'b1};
  assign tag_match = (cpu_address[15:4] == tag_q);
  assign unused_addr_bits = ^{cpu_address[0], snoop_address[3:0]};

  // A mismatching store in HOLD is not accepted; it waits for the drain.
  assign accept = cpu_write &&
                  ((state_q == StEmpty) || ((state_q == StHold) && tag_match));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q  <= '0;
      line_q <= '0;
      mask_q <= '0;
    end else begin
      tag_q  <= tag_d;
      line_q <= line_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    tag_d  = tag_q;
    line_d = line_q;
    mask_d = mask_q;
    if ((state_q == StDrain) && mem_resp) begin
      mask_d = '0;
    end
    if (accept && (cpu_wmask != 2'b00)) begin
      if (state_q == StEmpty) begin
        tag_d  = cpu_address[15:4];
        mask_d = '0;
      end
      if (cpu_wmask[0]) begin
        line_d[lo_base +: 8] = cpu_wdata[7:0];
        mask_d[lo_bit]       = 1'b1;
      end
      if (cpu_wmask[1]) begin
        line_d[hi_base +: 8] = cpu_wdata[15:8];
        mask_d[hi_bit]       = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (cpu_write && (cpu_wmask != 2'b00)) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (cpu_write && !tag_match) begin
          state_d = StDrain;
        end else if (flush || (mask_d == 16'hFFFF)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_resp) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    cpu_resp     = accept && !reset;
    empty        = (state_q == StEmpty);
    snoop_hit    = (state_q != StEmpty) && (snoop_address[15:4] == tag_q);
    mem_write    = (state_q == StDrain);
    mem_address  = {tag_q, 4'b0000};
    mem_wdata    = line_q;
    mem_bytemask = mask_q;
  end

endmodule

// File: tb/tb_write_line_buffer.sv
// Self-checking bench for write_line_buffer: a line model feeds a scoreboard of
// expected drains, popped whenever mem_write rises.
module tb_write_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_write;
  logic [15:0]  cpu_address;
  logic [15:0]  cpu_wdata;
  logic [1:0]   cpu_wmask;
  logic         cpu_resp;
  logic         flush;
  logic         empty;
  logic [15:0]  snoop_address;
  logic         snoop_hit;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_bytemask;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;
  bit auto_resp = 1'b0;

  typedef struct {
    logic [15:0]  addr;
    logic [15:0]  mask;
    logic [127:0] data;
  } drain_t;

  drain_t sb[$];

  logic [127:0] m_line = '0;
  logic [15:0]  m_mask = '0;
  logic [11:0]  m_tag = '0;
  bit           m_valid = 1'b0;

  write_line_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_wmask    (cpu_wmask),
    .cpu_resp     (cpu_resp),
    .flush        (flush),
    .empty        (empty),
    .snoop_address(snoop_address),
    .snoop_hit    (snoop_hit),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_bytemask (mem_bytemask),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  function automatic void model_merge(input logic [15:0] a, input logic [15:0] d,
                                      input logic [1:0] wm);
    int w;
    w = int'(a[3:1]);
    if (!m_valid && wm != 2'b00) begin
      m_valid = 1'b1;
      m_tag   = a[15:4];
      m_mask  = '0;
    end
    if (wm[0]) begin
      m_line[16*w +: 8] = d[7:0];
      m_mask[2*w]       = 1'b1;
    end
    if (wm[1]) begin
      m_line[16*w+8 +: 8] = d[15:8];
      m_mask[2*w+1]       = 1'b1;
    end
  endfunction

  function automatic void push_drain();
    drain_t e;
    e.addr = {m_tag, 4'h0};
    e.mask = m_mask;
    e.data = m_line;
    sb.push_back(e);
    m_valid = 1'b0;
    m_mask  = '0;
  endfunction

  // Returns the lower level's acceptance in the first DRAIN cycle when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_resp) mem_resp = mem_write;
    end
  end

  // Scoreboard pop on each new drain burst.
  logic prev_mw = 1'b0;
  always @(negedge clk) begin
    if (mem_write === 1'b1 && prev_mw !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: mem_address=%h mask=%h, required no drain",
                 mem_address, mem_bytemask);
      end else begin
        drain_t e;
        logic [127:0] bm;
        e = sb.pop_front();
        for (int i = 0; i < 16; i++) bm[8*i +: 8] = {8{e.mask[i]}};
        checks++;
        if (mem_address !== e.addr) begin
          errors++;
          $display("FAIL drain_addr: got %h, required %h", mem_address, e.addr);
        end
        checks++;
        if (mem_bytemask !== e.mask) begin
          errors++;
          $display("FAIL drain_mask: got %h, required %h", mem_bytemask, e.mask);
        end
        checks++;
        if ((mem_wdata & bm) !== (e.data & bm)) begin
          errors++;
          $display("FAIL drain_data: got %h, required %h", mem_wdata & bm, e.data & bm);
        end
      end
    end
    prev_mw = mem_write;
  end

  // Called at posedge+1; returns at posedge+1 with the store deasserted.
  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] wm,
                       input bit fl, output int cyc);
    if (m_valid && a[15:4] != m_tag) push_drain();
    cpu_write   = 1'b1;
    cpu_address = a;
    cpu_wdata   = d;
    cpu_wmask   = wm;
    flush       = fl;
    cyc = 0;
    #1;
    while (cpu_resp !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    checks++;
    if (cpu_resp !== 1'b1) begin
      errors++;
      $display("FAIL store_resp %h: cpu_resp=%b after %0d cycles, required 1", a, cpu_resp,
               cyc);
    end else begin
      model_merge(a, d, wm);
      if (m_valid && (fl || m_mask == 16'hFFFF)) push_drain();
    end
    @(posedge clk);
    #1;
    cpu_write = 1'b0;
    cpu_wmask = 2'b00;
    flush     = 1'b0;
  endtask

  task automatic do_flush();
    push_drain();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (empty !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_empty: empty=%b, required 1", name, empty);
    end
  endtask

  task automatic test_reset();
    int cyc;
    #1;
    checks++;
    if (empty !== 1'b1 || mem_write !== 1'b0 || cpu_resp !== 1'b0 ||
        mem_bytemask !== 16'h0 || mem_address !== 16'h0 || snoop_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: empty=%b mem_write=%b cpu_resp=%b mask=%h addr=%h hit=%b",
               empty, mem_write, cpu_resp, mem_bytemask, mem_address, snoop_hit);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    store(16'h7002, 16'h1234, 2'b11, 1'b0, cyc);
    cpu_write   = 1'b1;
    cpu_address = 16'h7004;
    cpu_wmask   = 2'b11;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || mem_write !== 1'b0 || cpu_resp !== 1'b0 ||
        mem_bytemask !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: empty=%b mem_write=%b cpu_resp=%b mask=%h, required 1/0/0/0",
               empty, mem_write, cpu_resp, mem_bytemask);
    end
    cpu_write = 1'b0;
    cpu_wmask = 2'b00;
    m_valid   = 1'b0;
    m_mask    = '0;
    m_line    = '0;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_merge_flush();
    int cyc;
    store(16'h1236, 16'hBEEF, 2'b11, 1'b0, cyc);
    store(16'h1231, 16'h00AA, 2'b01, 1'b0, cyc);
    do_flush();
    checks++;
    if (mem_write !== 1'b1 || mem_address !== 16'h1230) begin
      errors++;
      $display("FAIL merge_addr: mem_write=%b addr=%h, required 1 1230", mem_write,
               mem_address);
    end
    checks++;
    if (mem_bytemask !== 16'h00C1) begin
      errors++;
      $display("FAIL merge_mask: got %h, required 00c1", mem_bytemask);
    end
    checks++;
    if (mem_wdata[55:48] !== 8'hEF || mem_wdata[63:56] !== 8'hBE ||
        mem_wdata[7:0] !== 8'hAA) begin
      errors++;
      $display("FAIL merge_data: [63:48]=%h [7:0]=%h, required beef aa", mem_wdata[63:48],
               mem_wdata[7:0]);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_address !== 16'h1230 || mem_bytemask !== 16'h00C1 ||
          mem_wdata[63:48] !== 16'hBEEF || mem_wdata[7:0] !== 8'hAA) begin
        errors++;
        $display("FAIL merge_stable: mem_write=%b addr=%h mask=%h, required 1 1230 00c1",
                 mem_write, mem_address, mem_bytemask);
      end
    end
    mem_resp = 1'b1;
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    checks++;
    if (empty !== 1'b1 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL merge_release: empty=%b mem_write=%b, required 1 0", empty, mem_write);
    end
  endtask

  task automatic test_conflict();
    int cyc;
    auto_resp = 1'b1;
    store(16'h2000, 16'h1111, 2'b11, 1'b0, cyc);
    store(16'h3002, 16'h2222, 2'b11, 1'b0, cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL conflict_latency: resp after %0d edges, required 2", cyc);
    end
    checks++;
    if (mem_address !== 16'h3000 || mem_bytemask !== 16'h000C || empty !== 1'b0) begin
      errors++;
      $display("FAIL conflict_realloc: addr=%h mask=%h empty=%b, required 3000 000c 0",
               mem_address, mem_bytemask, empty);
    end
    do_flush();
    wait_empty("conflict");
    auto_resp = 1'b0;
    mem_resp  = 1'b0;
  endtask

  task automatic test_snoop_simultaneous();
    int cyc;
    store(16'h4000, 16'h0102, 2'b11, 1'b0, cyc);
    snoop_address = 16'h400E;
    #1;
    checks++;
    if (snoop_hit !== 1'b1) begin
      errors++;
      $display("FAIL snoop_hit: got %b, required 1", snoop_hit);
    end
    snoop_address = 16'h4010;
    #1;
    checks++;
    if (snoop_hit !== 1'b0) begin
      errors++;
      $display("FAIL snoop_miss: got %b, required 0", snoop_hit);
    end
    @(posedge clk);
    #1;
    store(16'h4004, 16'h0304, 2'b11, 1'b1, cyc);
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL store_flush_resp: resp after %0d edges, required 0", cyc);
    end
    checks++;
    if (mem_write !== 1'b1 || mem_bytemask !== 16'h0033) begin
      errors++;
      $display("FAIL store_flush_drain: mem_write=%b mask=%h, required 1 0033", mem_write,
               mem_bytemask);
    end
    auto_resp = 1'b1;
    wait_empty("snoop");
    auto_resp = 1'b0;
    mem_resp  = 1'b0;
    snoop_address = 16'h4000;
    #1;
    checks++;
    if (snoop_hit !== 1'b0) begin
      errors++;
      $display("FAIL snoop_empty: got %b, required 0", snoop_hit);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_line();
    int cyc;
    for (int i = 0; i < 8; i++) begin
      store(16'h4000 + 16'(2 * i), 16'hA000 + 16'(i * 16'h0101), 2'b11, 1'b0, cyc);
      checks++;
      if (cyc != 0) begin
        errors++;
        $display("FAIL full_b2b word %0d: resp after %0d edges, required 0", i, cyc);
      end
    end
    checks++;
    if (mem_write !== 1'b1 || mem_bytemask !== 16'hFFFF) begin
      errors++;
      $display("FAIL full_drain: mem_write=%b mask=%h, required 1 ffff", mem_write,
               mem_bytemask);
    end
    auto_resp = 1'b1;
    wait_empty("full");
    auto_resp = 1'b0;
    mem_resp  = 1'b0;
  endtask

  task automatic test_degenerate_reset_drain();
    int cyc;
    store(16'h5000, 16'hFFFF, 2'b00, 1'b0, cyc);
    checks++;
    if (cyc != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL degenerate: edges=%0d empty=%b, required 0 1", cyc, empty);
    end
    store(16'h6000, 16'h5555, 2'b11, 1'b0, cyc);
    do_flush();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_drain: mem_write=%b empty=%b, required 0 1", mem_write, empty);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    store(16'h6002, 16'h6666, 2'b11, 1'b0, cyc);
    checks++;
    if (mem_bytemask !== 16'h000C || mem_address !== 16'h6000 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL realloc: mask=%h addr=%h mem_write=%b, required 000c 6000 0",
               mem_bytemask, mem_address, mem_write);
    end
    auto_resp = 1'b1;
    do_flush();
    wait_empty("final");
    auto_resp = 1'b0;
    mem_resp  = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    cpu_write     = 1'b0;
    cpu_address   = '0;
    cpu_wdata     = '0;
    cpu_wmask     = 2'b00;
    flush         = 1'b0;
    snoop_address = '0;
    mem_resp      = 1'b0;
    test_reset();
    test_merge_flush();
    test_conflict();
    test_snoop_simultaneous();
    test_full_line();
    test_degenerate_reset_drain();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: %0d drains pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
